// File: rtl/alarm_clock_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_clock_ctrl
//
// Control FSM for the alarm-clock display path. Decodes debounced key levels
// into set modes, drives the display-mux select, emits one-cycle increment
// strobes to the time and alarm hour/minute counters (with hold-to-repeat),
// compares time against alarm and runs the buzzer.
//
// Optional feature: define SNOOZE_EN to add a SNOOZE ring state. Without it a
// key press while ringing cancels the alarm outright.
//
// Parameters
//   REPEAT_DLY  tick_fast strobes a hrs/mins key must be held before auto-repeat
//   RING_SEC    tick_1hz strobes the buzzer rings before it cancels itself
//   SNOOZE_SEC  tick_1hz strobes of snooze before re-ringing (SNOOZE_EN only)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   tick_1hz, tick_fast        one-cycle timebase strobes (1 Hz, 8 Hz)
//   key_time, key_alarm        debounced mode keys (levels)
//   key_hrs, key_mins          debounced increment keys (levels)
//   alarm_en                   alarm enable switch (level)
//   hours/mins/ampm_time       current time
//   hours/mins/ampm_alarm      alarm setting
//   alarm                      display select, 1 = alarm shown
//   time_run                   time counting enable, low while setting time
//   inc_hrs_t, inc_mins_t      increment strobes to the time counters
//   inc_hrs_a, inc_mins_a      increment strobes to the alarm counters
//   buzzer                     buzzer drive
//
// All outputs are registered and change one clock after their cause.
// -----------------------------------------------------------------------------
module alarm_clock_ctrl #(
  parameter int unsigned REPEAT_DLY = 4,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_fast,
  input  logic       key_time,
  input  logic       key_alarm,
  input  logic       key_hrs,
  input  logic       key_mins,
  input  logic       alarm_en,
  input  logic [3:0] hours_time,
  input  logic [5:0] mins_time,
  input  logic       ampm_time,
  input  logic [3:0] hours_alarm,
  input  logic [5:0] mins_alarm,
  input  logic       ampm_alarm,
  output logic       alarm,
  output logic       time_run,
  output logic       inc_hrs_t,
  output logic       inc_mins_t,
  output logic       inc_hrs_a,
  output logic       inc_mins_a,
  output logic       buzzer
);

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_SET_TIME,
    MODE_SET_ALARM
  } mode_e;

  typedef enum logic [1:0] {
    RING_QUIET,
    RING_ON,
    RING_SNOOZE
  } ring_e;

  localparam int unsigned HOLD_W  = $clog2(REPEAT_DLY + 1);
  localparam int unsigned SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int unsigned SEC_W   = $clog2(SEC_MAX + 1);

  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(REPEAT_DLY);
  localparam logic [SEC_W-1:0]  RING_LAST = SEC_W'(RING_SEC - 1);
`ifdef SNOOZE_EN
  localparam logic [SEC_W-1:0]  SNOOZE_LAST = SEC_W'(SNOOZE_SEC - 1);
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mode_e             mode_q, mode_nxt;
  ring_e             ring_q, ring_nxt;
  logic [SEC_W-1:0]  sec_q, sec_nxt;
  logic [HOLD_W-1:0] hold_hrs_q, hold_hrs_nxt;
  logic [HOLD_W-1:0] hold_mins_q, hold_mins_nxt;
  logic [3:0]        key_q;
  logic              edge_arm_q;
  logic              match_q;

  // ---------------------------------------------------------------------------
  // Key edges
  // ---------------------------------------------------------------------------
  // key_q clears to 0 on reset, so a key held through reset release would look
  // like a fresh press on the first clock. edge_arm_q masks that one clock,
  // during which key_q picks up the held level.
  logic [3:0] key_now;
  logic [3:0] rise_raw;
  logic       ringing;
  logic       any_rise;
  logic       rise_time, rise_alarm, rise_hrs, rise_mins;

  assign key_now  = {key_time, key_alarm, key_hrs, key_mins};
  assign rise_raw = key_now & ~key_q & {4{edge_arm_q}};
  assign any_rise = |rise_raw;
  assign ringing  = (ring_q != RING_QUIET);

  // While the buzzer is active any key press only silences it.
  assign {rise_time, rise_alarm, rise_hrs, rise_mins} = ringing ? 4'b0000 : rise_raw;

  // ---------------------------------------------------------------------------
  // Alarm match
  // ---------------------------------------------------------------------------
  logic match;
  logic trigger;

  assign match = alarm_en && (hours_time == hours_alarm) &&
                 (mins_time == mins_alarm) && (ampm_time == ampm_alarm);
  // Only a fresh match seen in RUN starts the buzzer; a match that appeared
  // while setting stays high in match_q and never produces an edge later.
  assign trigger = match && !match_q && (mode_q == MODE_RUN);

  // ---------------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------------
  logic setting;

  // NOTE: every combinational output gets a default before any branch; a path
  // that leaves a variable unassigned would otherwise infer a latch.
  always_comb begin
    mode_nxt = mode_q;
    unique case (mode_q)
      MODE_RUN: begin
        if (rise_alarm)     mode_nxt = MODE_SET_ALARM;
        else if (rise_time) mode_nxt = MODE_SET_TIME;
      end
      MODE_SET_TIME:  if (!key_time)  mode_nxt = MODE_RUN;
      MODE_SET_ALARM: if (!key_alarm) mode_nxt = MODE_RUN;
      default:        mode_nxt = MODE_RUN;
    endcase
  end

  // Strobes are allowed only while a set mode is held; the exit cycle is quiet.
  assign setting = (mode_q != MODE_RUN) && (mode_nxt == mode_q);

  // ---------------------------------------------------------------------------
  // Increment strobes with hold-to-repeat
  // ---------------------------------------------------------------------------
  // Returns {strobe, next hold count}. The count saturates at REPEAT_DLY; every
  // tick_fast that lands on the saturated value repeats the strobe.
  function automatic logic [HOLD_W:0] hold_step(input logic              active,
                                                input logic              key,
                                                input logic              rise,
                                                input logic              tick,
                                                input logic [HOLD_W-1:0] cnt);
    logic [HOLD_W-1:0] nxt;
    logic              strobe;
    nxt    = '0;
    strobe = 1'b0;
    if (active && key) begin
      nxt = cnt;
      if (tick && (cnt != HOLD_SAT)) nxt = cnt + HOLD_W'(1);
      strobe = rise || (tick && (nxt == HOLD_SAT));
    end
    return {strobe, nxt};
  endfunction

  logic strobe_hrs, strobe_mins;

  always_comb begin
    {strobe_hrs, hold_hrs_nxt}   = hold_step(setting, key_hrs, rise_hrs, tick_fast, hold_hrs_q);
    {strobe_mins, hold_mins_nxt} = hold_step(setting, key_mins, rise_mins, tick_fast, hold_mins_q);
  end

  // ---------------------------------------------------------------------------
  // Ring FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    ring_nxt = ring_q;
    sec_nxt  = sec_q;
    if (ringing && !alarm_en) begin
      ring_nxt = RING_QUIET;
      sec_nxt  = '0;
    end else begin
      unique case (ring_q)
        RING_QUIET: begin
          if (trigger) begin
            ring_nxt = RING_ON;
            sec_nxt  = '0;
          end
        end
        RING_ON: begin
          if (any_rise) begin
`ifdef SNOOZE_EN
            ring_nxt = RING_SNOOZE;
`else
            ring_nxt = RING_QUIET;
`endif
            sec_nxt  = '0;
          end else if (tick_1hz) begin
            if (sec_q == RING_LAST) begin
              ring_nxt = RING_QUIET;
              sec_nxt  = '0;
            end else begin
              sec_nxt = sec_q + SEC_W'(1);
            end
          end
        end
`ifdef SNOOZE_EN
        RING_SNOOZE: begin
          if (any_rise) begin
            ring_nxt = RING_QUIET;
            sec_nxt  = '0;
          end else if (tick_1hz) begin
            if (sec_q == SNOOZE_LAST) begin
              ring_nxt = RING_ON;
              sec_nxt  = '0;
            end else begin
              sec_nxt = sec_q + SEC_W'(1);
            end
          end
        end
`endif
        default: begin
          ring_nxt = RING_QUIET;
          sec_nxt  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_RUN;
      ring_q      <= RING_QUIET;
      sec_q       <= '0;
      hold_hrs_q  <= '0;
      hold_mins_q <= '0;
      key_q       <= '0;
      edge_arm_q  <= 1'b0;
      match_q     <= 1'b0;
      alarm       <= 1'b0;
      time_run    <= 1'b1;
      inc_hrs_t   <= 1'b0;
      inc_mins_t  <= 1'b0;
      inc_hrs_a   <= 1'b0;
      inc_mins_a  <= 1'b0;
      buzzer      <= 1'b0;
    end else begin
      mode_q      <= mode_nxt;
      ring_q      <= ring_nxt;
      sec_q       <= sec_nxt;
      hold_hrs_q  <= hold_hrs_nxt;
      hold_mins_q <= hold_mins_nxt;
      key_q       <= key_now;
      edge_arm_q  <= 1'b1;
      match_q     <= match;
      alarm       <= (mode_nxt == MODE_SET_ALARM);
      time_run    <= (mode_nxt != MODE_SET_TIME);
      inc_hrs_t   <= strobe_hrs  && (mode_q == MODE_SET_TIME);
      inc_mins_t  <= strobe_mins && (mode_q == MODE_SET_TIME);
      inc_hrs_a   <= strobe_hrs  && (mode_q == MODE_SET_ALARM);
      inc_mins_a  <= strobe_mins && (mode_q == MODE_SET_ALARM);
      buzzer      <= (ring_nxt == RING_ON);
    end
  end

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alarm_clock_ctrl
//
// Self-checking bench for alarm_clock_ctrl. A behavioural reference model runs
// on every rising clock edge from the applied inputs and queues the expected
// output vector; a monitor pops and compares on every falling edge. Directed
// scenarios (reset, set time, set alarm with auto-repeat, ring/self-cancel,
// key cancel, alarm_en cancel, reset mid-setting) are followed by a
// randomized phase.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alarm_clock_ctrl;

  localparam int RP = 4;    // REPEAT_DLY
  localparam int RS = 60;   // RING_SEC
  localparam int SS = 300;  // SNOOZE_SEC

  localparam int M_RUN   = 0;
  localparam int M_TIME  = 1;
  localparam int M_ALARM = 2;

  typedef struct packed {
    logic alarm;
    logic time_run;
    logic inc_hrs_t;
    logic inc_mins_t;
    logic inc_hrs_a;
    logic inc_mins_a;
    logic buzzer;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz, tick_fast;
  logic       key_time, key_alarm, key_hrs, key_mins;
  logic       alarm_en;
  logic [3:0] hours_time, hours_alarm;
  logic [5:0] mins_time, mins_alarm;
  logic       ampm_time, ampm_alarm;
  logic       alarm, time_run, inc_hrs_t, inc_mins_t, inc_hrs_a, inc_mins_a, buzzer;

  always #5 clk = ~clk;

  alarm_clock_ctrl #(
    .REPEAT_DLY(RP),
    .RING_SEC  (RS),
    .SNOOZE_SEC(SS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_1hz   (tick_1hz),
    .tick_fast  (tick_fast),
    .key_time   (key_time),
    .key_alarm  (key_alarm),
    .key_hrs    (key_hrs),
    .key_mins   (key_mins),
    .alarm_en   (alarm_en),
    .hours_time (hours_time),
    .mins_time  (mins_time),
    .ampm_time  (ampm_time),
    .hours_alarm(hours_alarm),
    .mins_alarm (mins_alarm),
    .ampm_alarm (ampm_alarm),
    .alarm      (alarm),
    .time_run   (time_run),
    .inc_hrs_t  (inc_hrs_t),
    .inc_mins_t (inc_mins_t),
    .inc_hrs_a  (inc_hrs_a),
    .inc_mins_a (inc_mins_a),
    .buzzer     (buzzer)
  );

  out_t dut_out;
  assign dut_out = {alarm, time_run, inc_hrs_t, inc_mins_t, inc_hrs_a, inc_mins_a, buzzer};

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  int n_hrs_t = 0, n_mins_t = 0, n_hrs_a = 0, n_mins_a = 0;

  out_t exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the user-visible rules, one step per rising clock edge.
  // Ringing is tracked as seconds still owed rather than as a state machine.
  // ---------------------------------------------------------------------------
  int m_mode;
  int ring_left;    // tick_1hz strobes of ringing still owed; 0 = silent
  int snooze_left;  // tick_1hz strobes of snooze still owed; 0 = not snoozing
  int held_h, held_m;
  bit armed, prev_match;
  bit pk_t, pk_a, pk_h, pk_m;

  task automatic model_step();
    out_t e;
    bit r_t, r_a, r_h, r_m, busy, keyhit, match, trig, stay, s_h, s_m;
    int old_mode;
    e = '0;
    if (!rst_n) begin
      m_mode = M_RUN; ring_left = 0; snooze_left = 0; held_h = 0; held_m = 0;
      armed = 0; prev_match = 0; pk_t = 0; pk_a = 0; pk_h = 0; pk_m = 0;
      e.time_run = 1'b1;
    end else begin
      // A key only counts as pressed if it was seen released since reset.
      r_t = armed && key_time  && !pk_t;
      r_a = armed && key_alarm && !pk_a;
      r_h = armed && key_hrs   && !pk_h;
      r_m = armed && key_mins  && !pk_m;
      armed = 1;
      pk_t = key_time; pk_a = key_alarm; pk_h = key_hrs; pk_m = key_mins;

      match = alarm_en && (hours_time == hours_alarm) && (mins_time == mins_alarm) &&
              (ampm_time == ampm_alarm);
      trig = match && !prev_match && (m_mode == M_RUN);
      prev_match = match;

      busy   = (ring_left > 0) || (snooze_left > 0);
      keyhit = busy && (r_t || r_a || r_h || r_m);
      if (busy) begin
        r_t = 0; r_a = 0; r_h = 0; r_m = 0;
      end

      if (busy && !alarm_en) begin
        ring_left = 0; snooze_left = 0;
      end else if (ring_left > 0) begin
        if (keyhit) begin
          ring_left = 0;
`ifdef SNOOZE_EN
          snooze_left = SS;
`endif
        end else if (tick_1hz) begin
          ring_left--;
        end
      end else if (snooze_left > 0) begin
        if (keyhit) snooze_left = 0;
        else if (tick_1hz) begin
          snooze_left--;
          if (snooze_left == 0) ring_left = RS;
        end
      end else if (trig) begin
        ring_left = RS;
      end

      old_mode = m_mode;
      stay = (m_mode == M_TIME && key_time) || (m_mode == M_ALARM && key_alarm);
      s_h = 0; s_m = 0;
      if (stay) begin
        if (key_hrs) begin
          if (tick_fast) held_h++;
          s_h = r_h || (tick_fast && held_h >= RP);
        end else held_h = 0;
        if (key_mins) begin
          if (tick_fast) held_m++;
          s_m = r_m || (tick_fast && held_m >= RP);
        end else held_m = 0;
      end else begin
        held_h = 0; held_m = 0;
      end

      if (m_mode == M_RUN) begin
        if (r_a)      m_mode = M_ALARM;
        else if (r_t) m_mode = M_TIME;
      end else if (!stay) begin
        m_mode = M_RUN;
      end

      e.alarm      = (m_mode == M_ALARM);
      e.time_run   = (m_mode != M_TIME);
      e.inc_hrs_t  = s_h && (old_mode == M_TIME);
      e.inc_mins_t = s_m && (old_mode == M_TIME);
      e.inc_hrs_a  = s_h && (old_mode == M_ALARM);
      e.inc_mins_a = s_m && (old_mode == M_ALARM);
      e.buzzer     = (ring_left > 0);
    end
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compare every registered output on the falling edge.
  // ---------------------------------------------------------------------------
  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("outputs@cycle%0d", cyc_n), 32'(dut_out), 32'(e));
        n_hrs_t  += int'(inc_hrs_t);
        n_mins_t += int'(inc_mins_t);
        n_hrs_a  += int'(inc_hrs_a);
        n_mins_a += int'(inc_mins_a);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 ns after the falling edge)
  // ---------------------------------------------------------------------------
  function automatic int strobes();
    return n_hrs_t + n_mins_t + n_hrs_a + n_mins_a;
  endfunction

  task automatic next();
    @(negedge clk);
    #1;
    tick_fast = 1'b0;
    tick_1hz  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) next();
  endtask

  task automatic fast_ticks(input int k, input int gap);
    repeat (k) begin
      tick_fast = 1'b1;
      next();
      idle(gap);
    end
  endtask

  task automatic sec_ticks(input int k, input int gap);
    repeat (k) begin
      tick_1hz = 1'b1;
      next();
      idle(gap);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios followed by random stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int base;
    rst_n = 1'b0; tick_1hz = 1'b0; tick_fast = 1'b0;
    key_time = 1'b0; key_alarm = 1'b0; key_hrs = 1'b0; key_mins = 1'b0;
    alarm_en = 1'b0;
    hours_time = 4'd12; mins_time = 6'd0;  ampm_time = 1'b0;
    hours_alarm = 4'd7; mins_alarm = 6'd30; ampm_alarm = 1'b0;
    idle(3);
    check("reset_time_run", 32'(time_run), 32'd1);
    check("reset_alarm", 32'(alarm), 32'd0);
    rst_n = 1'b1;

    // T1: idle with ticks running, no keys
    base = strobes();
    fast_ticks(100, 9);
    check("t1_no_strobes", 32'(strobes() - base), 32'd0);
    check("t1_time_run", 32'(time_run), 32'd1);
    check("t1_buzzer", 32'(buzzer), 32'd0);

    // T2: set time, single minute tap
    key_time = 1'b1; next(); idle(2);
    check("t2_time_run_low", 32'(time_run), 32'd0);
    base = n_mins_t;
    key_mins = 1'b1; next(); idle(2);
    key_mins = 1'b0; next(); idle(2);
    check("t2_one_inc_mins_t", 32'(n_mins_t - base), 32'd1);
    key_time = 1'b0; next(); idle(2);
    check("t2_back_to_run", 32'(time_run), 32'd1);

    // T3: set alarm, hold hours for 10 fast ticks
    key_alarm = 1'b1; next(); idle(2);
    check("t3_alarm_shown", 32'(alarm), 32'd1);
    base = n_hrs_a;
    key_hrs = 1'b1; next(); idle(1);
    fast_ticks(10, 2);
    key_hrs = 1'b0; next(); idle(2);
    check("t3_repeat_count", 32'(n_hrs_a - base), 32'(1 + (10 - RP + 1)));
    key_alarm = 1'b0; next(); idle(2);
    check("t3_alarm_hidden", 32'(alarm), 32'd0);

    // T4: time reaches 7:30 AM, ring for RS seconds
    hours_time = 4'd7; mins_time = 6'd29; alarm_en = 1'b1; idle(3);
    check("t4_quiet_before", 32'(buzzer), 32'd0);
    mins_time = 6'd30; next();
    check("t4_ring_start", 32'(buzzer), 32'd1);
    sec_ticks(RS - 1, 3);
    check("t4_still_ringing", 32'(buzzer), 32'd1);
    sec_ticks(1, 3);
    check("t4_self_cancel", 32'(buzzer), 32'd0);

    // T5: re-ring, key press silences it without side effects
    mins_time = 6'd29; next(); mins_time = 6'd30; next();
    check("t5_ring_again", 32'(buzzer), 32'd1);
    base = strobes();
    key_hrs = 1'b1; next();
    check("t5_key_stops_ring", 32'(buzzer), 32'd0);
    key_hrs = 1'b0; idle(3);
    check("t5_no_strobe", 32'(strobes() - base), 32'd0);
    check("t5_mode_run", 32'({alarm, time_run}), 32'b01);
`ifdef SNOOZE_EN
    sec_ticks(SS, 1);
    check("t5_snooze_rering", 32'(buzzer), 32'd1);
`else
    sec_ticks(5, 1);
    check("t5_stays_quiet", 32'(buzzer), 32'd0);
`endif

    // T6: alarm_en drop while ringing, then reset in the middle of SET_TIME
    mins_time = 6'd29; next(); mins_time = 6'd30; next();
    check("t6_ringing", 32'(buzzer), 32'd1);
    alarm_en = 1'b0; next();
    check("t6_alarm_en_off", 32'(buzzer), 32'd0);
    mins_time = 6'd31; next(); alarm_en = 1'b1; idle(2);
    key_time = 1'b1; next(); idle(1);
    key_mins = 1'b1; next();
    fast_ticks(3, 1);
    check("t6_setting", 32'(time_run), 32'd0);
    rst_n = 1'b0; #1;
    check("t6_async_reset", 32'(dut_out), 32'b0100000);
    idle(2);
    rst_n = 1'b1;
    fast_ticks(6, 1);
    check("t6_held_key_no_edge", 32'(time_run), 32'd1);
    key_time = 1'b0; key_mins = 1'b0; next();
    key_time = 1'b1; next();
    check("t6_fresh_press", 32'(time_run), 32'd0);
    key_time = 1'b0; idle(2);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) key_time  = ~key_time;
      if ($urandom_range(15) == 0) key_alarm = ~key_alarm;
      if ($urandom_range(11) == 0) key_hrs   = ~key_hrs;
      if ($urandom_range(11) == 0) key_mins  = ~key_mins;
      if ($urandom_range(199) == 0) alarm_en = ~alarm_en;
      if ($urandom_range(19) == 0) mins_time = ($urandom_range(1) == 0) ? 6'd30 : 6'd29;
      if ($urandom_range(49) == 0) hours_time = ($urandom_range(1) == 0) ? 4'd7 : 4'd8;
      if ($urandom_range(49) == 0) ampm_time = ~ampm_time;
      rst_n     = ($urandom_range(999) != 0);
      tick_fast = ($urandom_range(3) == 0);
      tick_1hz  = ($urandom_range(7) == 0);
      @(negedge clk);
      #1;
    end
    rst_n = 1'b1;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
